// File: rtl/mul_add_seq_if.sv
// Request/completion bundle for the shift-add multiply-accumulator.
// The master drives the request, the slave returns busy/result/o_valid.
interface mul_add_seq_if #(
  parameter int WIDTH = 8
);
  logic                 i_valid;
  logic [WIDTH-1:0]     multiplicand;
  logic [WIDTH-1:0]     multiplier;
  logic [WIDTH-1:0]     addend;
  logic                 busy;
  logic [2*WIDTH-1:0]   result;
  logic                 o_valid;

  modport master (
    output i_valid, multiplicand, multiplier, addend,
    input  busy, result, o_valid
  );

  modport slave (
    input  i_valid, multiplicand, multiplier, addend,
    output busy, result, o_valid
  );
endinterface

// File: rtl/mul_add_seq.sv
// Iterative shift-add multiply-accumulator: result = A*B + C after WIDTH RUN cycles.
// Fixed latency; requests arriving while busy are dropped.
module mul_add_seq #(
  parameter int WIDTH = 8
) (
  input  logic           clk,
  input  logic           rst_n,
  mul_add_seq_if.slave   bus
);
  localparam int CNT_W = $clog2(WIDTH + 1);

  typedef enum logic [1:0] {
    S_IDLE,
    S_RUN,
    S_DONE
  } state_t;

  state_t               r_state;
  state_t               w_state_nxt;
  logic [2*WIDTH-1:0]   r_acc;
  logic [2*WIDTH-1:0]   r_mcand;
  logic [WIDTH-1:0]     r_mplier;
  logic [CNT_W-1:0]     r_cnt;
  logic [2*WIDTH-1:0]   r_result;
  logic [2*WIDTH-1:0]   w_acc_nxt;
  logic                 w_accept;
  logic                 w_last;

  assign w_accept  = (r_state == S_IDLE) && bus.i_valid;
  assign w_last    = (r_state == S_RUN) && (r_cnt == CNT_W'(WIDTH - 1));
  assign w_acc_nxt = r_mplier[0] ? (r_acc + r_mcand) : r_acc;

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_state <= S_IDLE;
    end else begin
      r_state <= w_state_nxt;
    end
  end

  always_comb begin
    w_state_nxt = r_state;
    case (r_state)
      S_IDLE:  if (w_accept) w_state_nxt = S_RUN;
      S_RUN:   if (w_last)   w_state_nxt = S_DONE;
      S_DONE:                w_state_nxt = S_IDLE;
      default:               w_state_nxt = S_IDLE;
    endcase
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_acc    <= '0;
      r_mcand  <= '0;
      r_mplier <= '0;
      r_cnt    <= '0;
      r_result <= '0;
    end else if (w_accept) begin
      r_acc    <= {{WIDTH{1'b0}}, bus.addend};
      r_mcand  <= {{WIDTH{1'b0}}, bus.multiplicand};
      r_mplier <= bus.multiplier;
      r_cnt    <= '0;
    end else if (r_state == S_RUN) begin
      r_acc    <= w_acc_nxt;
      r_mcand  <= r_mcand << 1;
      r_mplier <= r_mplier >> 1;
      r_cnt    <= r_cnt + 1'b1;
      // The last iteration's sum goes straight to result so it is ready in DONE.
      if (w_last) r_result <= w_acc_nxt;
    end
  end

  assign bus.busy    = (r_state != S_IDLE);
  assign bus.o_valid = (r_state == S_DONE);
  assign bus.result  = r_result;
endmodule

// File: tb/tb_mul_add_seq.sv
// Self-checking bench for mul_add_seq: directed vectors, handshake/reset corners,
// random A*B+C and divider round-trip checks against plain arithmetic.
module tb_mul_add_seq;
  localparam int W = 8;

  logic clk;
  logic rst_n;
  int   checks = 0;
  int   errors = 0;

  mul_add_seq_if #(.WIDTH(W)) bus ();

  mul_add_seq #(.WIDTH(W)) dut (
    .clk   (clk),
    .rst_n (rst_n),
    .bus   (bus)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  typedef struct {
    logic [W-1:0]   a;
    logic [W-1:0]   b;
    logic [W-1:0]   c;
    logic [2*W-1:0] exp;
    string          name;
  } vec_t;

  vec_t vecs[7];

  task automatic check(input string nm, input longint act, input longint req);
    checks++;
    if (act != req) begin
      errors++;
      $display("FAIL %s actual %0d required %0d", nm, act, req);
    end
  endtask

  // Issue one request and watch the full window: latency, pulse count, busy length, result.
  task automatic run_op(input logic [W-1:0] a, input logic [W-1:0] b,
                        input logic [W-1:0] c, input logic [2*W-1:0] req,
                        input string nm);
    int first_ov = -1;
    int n_ov = 0;
    int n_busy = 0;
    logic [2*W-1:0] res_at = '0;
    bus.i_valid      = 1'b1;
    bus.multiplicand = a;
    bus.multiplier   = b;
    bus.addend       = c;
    @(posedge clk);
    #1;
    bus.i_valid      = 1'b0;
    bus.multiplicand = ~a;
    bus.multiplier   = ~b;
    bus.addend       = ~c;
    for (int n = 0; n < W + 3; n++) begin
      @(negedge clk);
      if (bus.busy) n_busy++;
      if (bus.o_valid) begin
        n_ov++;
        if (first_ov < 0) begin
          first_ov = n;
          res_at   = bus.result;
        end
      end
    end
    check({nm, " latency"}, first_ov, W);
    check({nm, " o_valid_pulses"}, n_ov, 1);
    check({nm, " busy_cycles"}, n_busy, W + 1);
    check({nm, " result"}, res_at, req);
    check({nm, " result_hold"}, bus.result, req);
  endtask

  initial begin
    int first_ov;
    int n_ov;
    int n_busy_late;
    logic [2*W-1:0] res_at;
    int dividend;
    int divisor;
    int a;
    int b;
    int c;

    vecs[0] = '{a: 8'd12,  b: 8'd13,  c: 8'd5,   exp: 16'd161,   name: "basic"};
    vecs[1] = '{a: 8'd255, b: 8'd255, c: 8'd255, exp: 16'd65280, name: "max"};
    vecs[2] = '{a: 8'd0,   b: 8'd200, c: 8'd7,   exp: 16'd7,     name: "zero_a"};
    vecs[3] = '{a: 8'd1,   b: 8'd0,   c: 8'd0,   exp: 16'd0,     name: "zero_b"};
    vecs[4] = '{a: 8'd100, b: 8'd50,  c: 8'd3,   exp: 16'd5003,  name: "mid"};
    vecs[5] = '{a: 8'd255, b: 8'd1,   c: 8'd0,   exp: 16'd255,   name: "b_one"};
    vecs[6] = '{a: 8'd128, b: 8'd128, c: 8'd1,   exp: 16'd16385, name: "msb"};

    rst_n            = 1'b0;
    bus.i_valid      = 1'b0;
    bus.multiplicand = '0;
    bus.multiplier   = '0;
    bus.addend       = '0;
    repeat (3) @(negedge clk);
    check("reset busy", bus.busy, 0);
    check("reset o_valid", bus.o_valid, 0);
    check("reset result", bus.result, 0);
    rst_n = 1'b1;
    @(negedge clk);

    foreach (vecs[i]) run_op(vecs[i].a, vecs[i].b, vecs[i].c, vecs[i].exp, vecs[i].name);

    // Ignored request: hold i_valid with other operands for the whole busy window.
    bus.i_valid      = 1'b1;
    bus.multiplicand = 8'd12;
    bus.multiplier   = 8'd13;
    bus.addend       = 8'd5;
    @(posedge clk);
    #1;
    bus.i_valid = 1'b0;
    first_ov = -1;
    n_ov = 0;
    n_busy_late = 0;
    res_at = '0;
    for (int n = 0; n < 15; n++) begin
      @(negedge clk);
      if (bus.o_valid) begin
        n_ov++;
        if (first_ov < 0) begin
          first_ov = n;
          res_at   = bus.result;
        end
      end
      if (n >= W + 1 && bus.busy) n_busy_late++;
      if (n == 2) begin
        bus.i_valid      = 1'b1;
        bus.multiplicand = 8'd3;
        bus.multiplier   = 8'd3;
        bus.addend       = 8'd0;
      end
      if (n == W) bus.i_valid = 1'b0;
    end
    check("ignored latency", first_ov, W);
    check("ignored o_valid_pulses", n_ov, 1);
    check("ignored result", res_at, 161);
    check("ignored no_accept", n_busy_late, 0);
    check("ignored result_hold", bus.result, 161);

    // Reset in the 4th RUN cycle aborts the operation.
    bus.i_valid      = 1'b1;
    bus.multiplicand = 8'd200;
    bus.multiplier   = 8'd200;
    bus.addend       = 8'd0;
    @(posedge clk);
    #1;
    bus.i_valid = 1'b0;
    repeat (4) @(negedge clk);
    check("abort busy_before", bus.busy, 1);
    rst_n = 1'b0;
    #1;
    check("abort busy", bus.busy, 0);
    check("abort o_valid", bus.o_valid, 0);
    check("abort result", bus.result, 0);
    @(negedge clk);
    rst_n = 1'b1;
    n_ov = 0;
    for (int n = 0; n < 12; n++) begin
      @(negedge clk);
      if (bus.o_valid) n_ov++;
    end
    check("abort no_o_valid", n_ov, 0);
    check("abort result_after", bus.result, 0);
    run_op(8'd2, 8'd3, 8'd1, 16'd7, "after_abort");

    for (int i = 0; i < 200; i++) begin
      a = int'($urandom_range(0, 255));
      b = int'($urandom_range(0, 255));
      c = int'($urandom_range(0, 255));
      run_op(a[W-1:0], b[W-1:0], c[W-1:0], 16'(a * b + c), "rand");
    end

    // Divider round-trip: divisor*q + rem must rebuild the dividend.
    for (int i = 0; i < 1000; i++) begin
      dividend = int'($urandom_range(0, 255));
      divisor  = int'($urandom_range(1, 255));
      a = divisor;
      b = dividend / divisor;
      c = dividend % divisor;
      run_op(a[W-1:0], b[W-1:0], c[W-1:0], 16'(dividend), "divrt");
    end

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end
endmodule

// File: doc/mul_add_seq.md
# mul_add_seq

Iterative shift-add multiply-accumulator. It computes result = multiplicand × multiplier + addend over WIDTH clock cycles and uses the same valid/busy handshake as the integer divider. It is the inverse of the divider: feeding it the divider's outputs as (divisor, q, rem) reconstructs the dividend. The block is used as the reference model for divider checking in the integer-divider subsystem, and as a standalone low-area multiplier.

## Interface

- WIDTH, default 8: operand width in bits; the result is 2*WIDTH bits.
- clk, input, 1: clock; all state updates on the rising edge.
- rst_n, input, 1: reset, asynchronous, active-low.
- i_valid, input, 1: request strobe; sampled on rising clk.
- multiplicand, input, WIDTH: unsigned operand A.
- multiplier, input, WIDTH: unsigned operand B.
- addend, input, WIDTH: unsigned operand C, zero-extended to 2*WIDTH.
- busy, output, 1: high while an operation is in flight (states RUN and DONE).
- result, output, 2*WIDTH: A*B + C.
  - Valid when o_valid=1.
  - Holds its value until the next completion.
- o_valid, output, 1: single-cycle completion pulse.

## Operation

- States: IDLE, RUN, DONE.
  - busy = (state != IDLE).
  - o_valid = (state == DONE).
- Datapath registers:
  - acc: 2*WIDTH bits.
  - mcand: 2*WIDTH bits; A, shifted left once per iteration.
  - mplier: WIDTH bits; B, shifted right once per iteration.
  - cnt: $clog2(WIDTH+1) bits.
- IDLE:
  - On a rising edge with i_valid=1, load acc = {0, addend}, mcand = {0, multiplicand}, mplier = multiplier, cnt = 0, and go to RUN.
  - With i_valid=0, stay in IDLE.
- RUN, each cycle:
  - If mplier[0]=1, acc <= acc + mcand; otherwise acc is unchanged.
  - mcand <= mcand << 1; mplier <= mplier >> 1; cnt <= cnt + 1.
  - On the cycle where cnt == WIDTH-1, go to DONE and register the final acc into result.
- DONE: lasts exactly one cycle; o_valid=1; then return to IDLE.
- Arithmetic and width rules:
  - Operands are unsigned.
  - The maximum value (2^W−1)² + (2^W−1) = 2^2W − 2^W fits in 2*WIDTH bits, so overflow cannot occur and no carry-out is kept.
  - There is no early termination: latency is fixed regardless of operand values, including zero.
- Handshake rules:
  - i_valid while busy=1 (RUN or DONE) is ignored. The in-flight operation and its operands are unaffected, and there is no error flag.
  - A new request is accepted on the first edge with state IDLE. The earliest is the edge that ends the DONE cycle plus one, i.e. the cycle after o_valid.
  - Operand inputs only need to be stable on the accept edge.
- Reset:
  - rst_n=0 forces IDLE immediately (asynchronously).
  - Output values in reset: busy=0, o_valid=0, result=0. acc, mcand, mplier and cnt clear to 0.
  - Reset mid-operation aborts the operation. No o_valid is produced for it, and result reads 0 after reset.
  - After rst_n deasserts, the first edge may accept a request.

## Timing

- Let E0 be the accept edge (IDLE with i_valid=1).
- After E0: busy=1, state RUN.
- Edges E1..E(WIDTH) perform the WIDTH iterations.
- After E(WIDTH): state DONE, o_valid=1, result final.
- After E(WIDTH+1): state IDLE, busy=0, o_valid=0.
- Latency from accept edge to o_valid high is WIDTH cycles; o_valid lasts 1 cycle.
- busy is high for WIDTH+1 cycles per operation.
- Throughput is one operation per WIDTH+2 cycles when back-to-back. For WIDTH=8: 10 cycles.
- All outputs are registered; there is no combinational path from inputs to outputs.

## Test plan

- Basic: A=12, B=13, C=5, WIDTH=8, i_valid for one cycle -> busy high for 9 cycles; o_valid for one cycle at 8 cycles after accept; result=161.
- Maximum: A=255, B=255, C=255 -> result=65280 (0xFF00), with no wrap.
- Zero operands: A=0, B=200, C=7 -> result=7 with the same 8-cycle latency. Also A=1, B=0, C=0 -> result=0.
- Ignored request: during busy, present i_valid with A=3, B=3, C=0 -> only the original result appears; no second o_valid occurs; no acceptance until IDLE.
- Reset mid-operation: pulse rst_n low during cycle 4 of RUN -> busy=0, o_valid=0, result=0 immediately; no o_valid follows. A new request (A=2, B=3, C=1) then yields 7.
- Divider round-trip: random dividend, nonzero divisor through the divider; feed (divisor, q, rem) -> result equals the zero-extended dividend for 1000 random pairs.
